debounce_filter: RTL and testbench

Synchronous input-conditioning stage that sits directly upstream of the basic logic-gate cells: it takes a raw, possibly bouncing single-bit input (switch or button), synchronises it, and drives a clean, debounced level onto the gate input `a`. It also emits one-cycle rise/fall strobes and keeps a wrap-around count of accepted rising edges for downstream observation. It is a 2-flop synchroniser followed by a 2-state consecutive-sample filter FSM.

---
 rtl/debounce_filter.sv | 101 ++++++++++
 tb/tb_debounce_filter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Debounce filter: 2-flop synchroniser followed by a consecutive-sample
// qualification FSM. Emits a clean level, one-cycle rise/fall strobes and a
// wrap-around count of accepted rising edges. All outputs are registered.
module debounce_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             y,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_count
);

    typedef enum logic {StIdle, StCheck} state_t;

    localparam logic [7:0]       CntLast = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic s1, s2;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic y_d, rise_d, fall_d;
    logic [CNT_W-1:0] edge_count_d;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= a;
            s2 <= s1;
        end
    end

    // Filter state and output registers; reset discards any qualification.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            y          <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            edge_count <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            y          <= y_d;
            rise       <= rise_d;
            fall       <= fall_d;
            edge_count <= edge_count_d;
        end
    end

    // Next-state logic: time a disagreeing level, restart on any bounce.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        y_d          = y;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        edge_count_d = edge_count;

        unique case (state_q)
            StIdle: begin
                if (s2 != y) begin
                    state_d = StCheck;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            StCheck: begin
                if (s2 == y) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    y_d     = ~y;
                    if (!y) begin
                        rise_d       = 1'b1;
                        edge_count_d = edge_count + CntOne;
                    end else begin
                        fall_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter (STABLE_CYCLES=4, CNT_W=8).
`timescale 1ns/1ps
module tb_debounce_filter;

    logic       clk;
    logic       rst;
    logic       a;
    logic       y;
    logic       rise;
    logic       fall;
    logic [7:0] edge_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_cnt;

    debounce_filter #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .y         (y),
        .rise      (rise),
        .fall      (fall),
        .edge_count(edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       rst;
        logic       y;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic va, input logic vrst, input logic vy, input logic vr,
                       input logic vf, input logic [7:0] vc, input string nm, input int n);
        vec_t v;
        v.a = va; v.rst = vrst; v.y = vy; v.rise = vr; v.fall = vf; v.cnt = vc; v.name = nm;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic ey, input logic er, input logic ef,
                         input logic [7:0] ec);
        n_checks++;
        if ({y, rise, fall, edge_count} !== {ey, er, ef, ec}) begin
            n_fail++;
            $display("FAIL %s: got y/rise/fall/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     nm, y, rise, fall, edge_count, ey, er, ef, ec);
        end
    endtask

    // One clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a new level and hold it until accepted, checking every edge.
    task automatic press(input logic v, input string nm);
        a = v;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 6 && v) model_cnt = model_cnt + 8'd1;
            check(nm, (i >= 6) ? v : ~v, (i == 6) && v, (i == 6) && !v, model_cnt);
        end
    endtask

    initial begin
        logic bounce_pat [15];
        rst = 1'b1;
        a   = 1'b0;

        // Reset
        add(0, 1, 0, 0, 0, 0, "reset", 3);
        add(0, 0, 0, 0, 0, 0, "idle_after_reset", 2);
        // Clean press: edges 1..5 quiet, y and rise at edge 6, rise clears at 7
        add(1, 0, 0, 0, 0, 0, "press_wait", 5);
        add(1, 0, 1, 1, 0, 1, "press_rise", 1);
        add(1, 0, 1, 0, 0, 1, "press_hold", 2);
        // Clean release
        add(0, 0, 1, 0, 0, 1, "release_wait", 5);
        add(0, 0, 0, 0, 1, 1, "release_fall", 1);
        add(0, 0, 0, 0, 0, 1, "release_hold", 1);
        // 3-edge glitch rejected
        add(1, 0, 0, 0, 0, 1, "glitch3_hi", 3);
        add(0, 0, 0, 0, 0, 1, "glitch3_lo", 6);
        // 4-edge pulse accepted, then released
        add(1, 0, 0, 0, 0, 1, "pulse4_hi", 4);
        add(0, 0, 0, 0, 0, 1, "pulse4_wait", 1);
        add(0, 0, 1, 1, 0, 2, "pulse4_rise", 1);
        add(0, 0, 1, 0, 0, 2, "pulse4_high", 3);
        add(0, 0, 0, 0, 1, 2, "pulse4_fall", 1);
        add(0, 0, 0, 0, 0, 2, "pulse4_low", 2);
        // Reset mid-CHECK: rst at edge 4, then requalify from scratch
        add(1, 0, 0, 0, 0, 2, "midchk_pre", 3);
        add(1, 1, 0, 0, 0, 0, "midchk_rst", 1);
        add(1, 0, 0, 0, 0, 0, "midchk_wait", 5);
        add(1, 0, 1, 1, 0, 1, "midchk_rise", 1);
        add(1, 0, 1, 0, 0, 1, "midchk_hold", 2);

        foreach (vecs[i]) begin
            a   = vecs[i].a;
            rst = vecs[i].rst;
            step();
            check(vecs[i].name, vecs[i].y, vecs[i].rise, vecs[i].fall, vecs[i].cnt);
        end
        rst = 1'b0;
        model_cnt = 8'd1;

        // Bring y back to 0, then bounce 1,0,1,0,1 and hold 1
        press(1'b0, "pre_bounce_release");
        bounce_pat = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int e = 1; e <= 15; e++) begin
            a = bounce_pat[e-1];
            step();
            if (e == 10) model_cnt = model_cnt + 8'd1;
            check("bounce", e >= 10, e == 10, 1'b0, model_cnt);
        end

        // Wrap-around: reset, then 256 accepted presses
        a   = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_cnt = 8'd0;
        check("wrap_reset", 1'b0, 1'b0, 1'b0, model_cnt);
        for (int p = 0; p < 256; p++) begin
            press(1'b1, "wrap_press");
            press(1'b0, "wrap_release");
        end
        n_checks++;
        if (edge_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_final: got edge_count=%0d required 0", edge_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
